// File: rtl/pdm_deserializer_if.sv
// pdm_deserializer_if: controller/microphone-side signals of the PDM deserializer
interface pdm_deserializer_if #(
  parameter int WORD_W = 16
);
  logic                         D_enable;
  logic                         pdm_data_i;
  logic                         M_CLK;
  logic                         M_LRSEL;
  logic [WORD_W-1:0]            data_o;
  logic [$clog2(WORD_W+1)-1:0]  ones_o;
  logic                         one_done;
  modport master (
    output D_enable, pdm_data_i,
    input  M_CLK, M_LRSEL, data_o, ones_o, one_done
  );
  modport slave (
    input  D_enable, pdm_data_i,
    output M_CLK, M_LRSEL, data_o, ones_o, one_done
  );
endinterface

// File: rtl/pdm_deserializer.sv
// pdm_deserializer: generates the PDM mic clock and packs rising-edge samples into words
module pdm_deserializer #(
  parameter int CLK_DIV = 50,
  parameter int WORD_W  = 16
) (
  input  logic             clock_i,
  input  logic             Reset_n,
  pdm_deserializer_if.slave bus
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(WORD_W);
  localparam int OW = $clog2(WORD_W+1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t              r_state, w_state;
  logic [DW-1:0]       r_div, w_div;
  logic                r_mclk, w_mclk;
  logic [BW-1:0]       r_bit, w_bit;
  logic [WORD_W-2:0]   r_shift, w_shift;
  logic [OW-1:0]       r_acc, w_acc;
  logic [WORD_W-1:0]   r_data, w_data;
  logic [OW-1:0]       r_ones, w_ones;
  logic                r_done, w_done;
  logic                w_wrap;
  logic                w_rise;
  logic [WORD_W-1:0]   w_word;
  assign w_wrap = r_div == DW'(CLK_DIV-1);
  assign w_rise = r_state == RUN && bus.D_enable && w_wrap && !r_mclk;
  assign w_word = {r_shift, bus.pdm_data_i};
  assign bus.M_CLK    = r_mclk;
  assign bus.M_LRSEL  = 1'b0;
  assign bus.data_o   = r_data;
  assign bus.ones_o   = r_ones;
  assign bus.one_done = r_done;
  // state and datapath registers; reset clears everything without waiting for a clock
  always_ff @(posedge clock_i or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_mclk  <= 1'b0;
      r_bit   <= '0;
      r_shift <= '0;
      r_acc   <= '0;
      r_data  <= '0;
      r_ones  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_mclk  <= w_mclk;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_acc   <= w_acc;
      r_data  <= w_data;
      r_ones  <= w_ones;
      r_done  <= w_done;
    end
  end
  // next state: dropping D_enable always wins, discarding any partial word
  always_comb begin
    w_state = r_state;
    w_div   = r_div;
    w_mclk  = r_mclk;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_acc   = r_acc;
    w_data  = r_data;
    w_ones  = r_ones;
    w_done  = 1'b0;
    if (!bus.D_enable) begin
      w_state = IDLE;
      w_div   = '0;
      w_mclk  = 1'b0;
      w_bit   = '0;
      w_shift = '0;
      w_acc   = '0;
    end else if (r_state == IDLE) begin
      w_state = RUN;
    end else begin
      w_div  = w_wrap ? '0 : r_div + 1'b1;
      w_mclk = r_mclk ^ w_wrap;
      if (w_rise) begin
        w_shift = w_word[WORD_W-2:0];
        if (r_bit == BW'(WORD_W-1)) begin
          w_data = w_word;
          w_ones = r_acc + OW'(bus.pdm_data_i);
          w_done = 1'b1;
          w_bit  = '0;
          w_acc  = '0;
        end else begin
          w_bit = r_bit + 1'b1;
          w_acc = r_acc + OW'(bus.pdm_data_i);
        end
      end
    end
  end
endmodule

// File: tb/tb_pdm_deserializer.sv
// tb_pdm_deserializer: directed checks of clock timing, word packing, disable and reset behaviour
module tb_pdm_deserializer;
  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  int k = 0;
  pdm_deserializer_if #(.WORD_W(16)) bus ();
  pdm_deserializer #(.CLK_DIV(50), .WORD_W(16)) dut (
    .clock_i(clk),
    .Reset_n(rst_n),
    .bus(bus.slave)
  );
  always #5 if (clk_en) clk = ~clk;
  task automatic advance(input int to_edge, input logic [15:0] pat,
                         output int n_done, output int first_done, output int mclk_bad);
    n_done = 0;
    first_done = -1;
    mclk_bad = 0;
    while (k <= to_edge) begin
      if (k >= 50 && (k - 50) % 100 == 0) bus.pdm_data_i = pat[15 - ((k - 50) / 100) % 16];
      else bus.pdm_data_i = ~pat[15 - ((k + 50) / 100) % 16];
      @(posedge clk); #1;
      if (bus.one_done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      if (bus.M_CLK !== (((k / 50) % 2) == 1)) mclk_bad++;
      k++;
    end
  endtask
  task automatic idle_ticks(input int n, output int bad);
    bad = 0;
    repeat (n) begin
      bus.pdm_data_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (bus.M_CLK !== 1'b0 || bus.one_done !== 1'b0) bad++;
    end
  endtask
  task automatic enter();
    bus.D_enable = 1'b1;
    k = 0;
  endtask
  task automatic test_reset();
    int bad;
    bus.D_enable = 1'b0;
    bus.pdm_data_i = 1'b0;
    #3 rst_n = 1'b0;
    #2;
    checks++; if (bus.M_CLK !== 1'b0) begin errors++; $display("FAIL reset_mclk got %b want 0", bus.M_CLK); end
    checks++; if (bus.one_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.one_done); end
    checks++; if (bus.data_o !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", bus.data_o); end
    checks++; if (bus.ones_o !== 5'd0) begin errors++; $display("FAIL reset_ones got %0d want 0", bus.ones_o); end
    checks++; if (bus.M_LRSEL !== 1'b0) begin errors++; $display("FAIL reset_lrsel got %b want 0", bus.M_LRSEL); end
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_ticks(5, bad);
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_quiet got %0d bad cycles want 0", bad); end
  endtask
  task automatic test_all_ones();
    int nd, fd, mb;
    enter();
    advance(1549, 16'hFFFF, nd, fd, mb);
    checks++; if (nd != 0) begin errors++; $display("FAIL ones_early_done got %0d want 0", nd); end
    checks++; if (bus.data_o !== 16'h0) begin errors++; $display("FAIL ones_data_before got %h want 0000", bus.data_o); end
    checks++; if (mb != 0) begin errors++; $display("FAIL ones_mclk_timing got %0d bad edges want 0", mb); end
    advance(1551, 16'hFFFF, nd, fd, mb);
    checks++; if (nd != 1 || fd != 1550) begin errors++; $display("FAIL ones_done got %0d pulses at edge %0d want 1 at 1550", nd, fd); end
    checks++; if (bus.data_o !== 16'hFFFF) begin errors++; $display("FAIL ones_data got %h want ffff", bus.data_o); end
    checks++; if (bus.ones_o !== 5'd16) begin errors++; $display("FAIL ones_count got %0d want 16", bus.ones_o); end
  endtask
  task automatic test_alternating();
    int nd, fd, mb;
    advance(3151, 16'hAAAA, nd, fd, mb);
    checks++; if (nd != 1 || fd != 3150) begin errors++; $display("FAIL alt_done got %0d pulses at edge %0d want 1 at 3150", nd, fd); end
    checks++; if (bus.data_o !== 16'hAAAA) begin errors++; $display("FAIL alt_data got %h want aaaa", bus.data_o); end
    checks++; if (bus.ones_o !== 5'd8) begin errors++; $display("FAIL alt_count got %0d want 8", bus.ones_o); end
    checks++; if (mb != 0) begin errors++; $display("FAIL alt_mclk got %0d bad edges want 0", mb); end
  endtask
  task automatic test_back_to_back();
    int nd, fd, mb;
    advance(4751, 16'h1234, nd, fd, mb);
    checks++; if (nd != 1 || fd != 4750) begin errors++; $display("FAIL b2b_done got %0d pulses at edge %0d want 1 at 4750", nd, fd); end
    checks++; if (bus.data_o !== 16'h1234) begin errors++; $display("FAIL b2b_data got %h want 1234", bus.data_o); end
    checks++; if (bus.ones_o !== 5'd5) begin errors++; $display("FAIL b2b_count got %0d want 5", bus.ones_o); end
  endtask
  task automatic test_partial_disable();
    int nd, fd, mb, bad;
    advance(5560, 16'hFFFF, nd, fd, mb);
    bus.D_enable = 1'b0;
    idle_ticks(10, bad);
    checks++; if (nd != 0 || bad != 0) begin errors++; $display("FAIL partial_idle got %0d pulses %0d bad idle cycles want 0 0", nd, bad); end
    checks++; if (bus.data_o !== 16'h1234) begin errors++; $display("FAIL partial_hold got %h want 1234", bus.data_o); end
    enter();
    advance(1549, 16'hC3A5, nd, fd, mb);
    checks++; if (nd != 0 || bus.data_o !== 16'h1234) begin errors++; $display("FAIL partial_fresh got %0d pulses data %h want 0 1234", nd, bus.data_o); end
    advance(1551, 16'hC3A5, nd, fd, mb);
    checks++; if (nd != 1 || fd != 1550) begin errors++; $display("FAIL partial_done got %0d pulses at edge %0d want 1 at 1550", nd, fd); end
    checks++; if (bus.data_o !== 16'hC3A5 || bus.ones_o !== 5'd8) begin errors++; $display("FAIL partial_word got %h/%0d want c3a5/8", bus.data_o, bus.ones_o); end
  endtask
  task automatic test_disable_on_last();
    int nd, fd, mb, bad;
    advance(3149, 16'hF00F, nd, fd, mb);
    bus.D_enable = 1'b0;
    bus.pdm_data_i = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.one_done !== 1'b0 || bus.M_CLK !== 1'b0) begin errors++; $display("FAIL last_edge got done %b mclk %b want 0 0", bus.one_done, bus.M_CLK); end
    idle_ticks(4, bad);
    checks++; if (nd != 0 || bad != 0) begin errors++; $display("FAIL last_quiet got %0d pulses %0d bad want 0 0", nd, bad); end
    checks++; if (bus.data_o !== 16'hC3A5 || bus.ones_o !== 5'd8) begin errors++; $display("FAIL last_hold got %h/%0d want c3a5/8", bus.data_o, bus.ones_o); end
    enter();
    advance(1551, 16'h0001, nd, fd, mb);
    checks++; if (nd != 1 || fd != 1550 || bus.data_o !== 16'h0001 || bus.ones_o !== 5'd1) begin errors++; $display("FAIL last_reentry got %0d pulses edge %0d data %h ones %0d want 1 1550 0001 1", nd, fd, bus.data_o, bus.ones_o); end
  endtask
  task automatic test_reset_mid_word();
    int nd, fd, mb;
    enter();
    advance(460, 16'hFFFF, nd, fd, mb);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.data_o !== 16'h0 || bus.ones_o !== 5'd0) begin errors++; $display("FAIL rstmid_data got %h/%0d want 0000/0", bus.data_o, bus.ones_o); end
    checks++; if (bus.M_CLK !== 1'b0 || bus.one_done !== 1'b0 || bus.M_LRSEL !== 1'b0) begin errors++; $display("FAIL rstmid_ctl got mclk %b done %b lrsel %b want 0 0 0", bus.M_CLK, bus.one_done, bus.M_LRSEL); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    k = 0;
    advance(1549, 16'h8001, nd, fd, mb);
    checks++; if (nd != 0 || mb != 0) begin errors++; $display("FAIL rstmid_early got %0d pulses %0d mclk errors want 0 0", nd, mb); end
    advance(1551, 16'h8001, nd, fd, mb);
    checks++; if (nd != 1 || fd != 1550) begin errors++; $display("FAIL rstmid_done got %0d pulses at edge %0d want 1 at 1550", nd, fd); end
    checks++; if (bus.data_o !== 16'h8001 || bus.ones_o !== 5'd2) begin errors++; $display("FAIL rstmid_word got %h/%0d want 8001/2", bus.data_o, bus.ones_o); end
  endtask
  initial begin
    test_reset();
    test_all_ones();
    test_alternating();
    test_back_to_back();
    test_partial_disable();
    test_disable_on_last();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pdm_deserializer.md
PDM_DESERIALIZER -- requirements
Module: pdm_deserializer

Interface
REQ-001 Parameter CLK_DIV, default 50: clock_i cycles per M_CLK half-period (M_CLK = f(clock_i) / (2*CLK_DIV)); legal range >= 2.
REQ-002 Parameter WORD_W, default 16: PDM samples packed per output word; legal range 2..32.
REQ-003 Port clock_i  input  1: single system clock; all logic on its rising edge.
REQ-004 Port Reset_n  input  1: reset, asynchronous assert, active-low.
REQ-005 Port D_enable  input  1: capture enable, driven by the record/play controller.
REQ-006 Port pdm_data_i  input  1: microphone PDM data, pre-synchronised upstream.
REQ-007 Port M_CLK  output  1: microphone clock, registered, glitch-free.
REQ-008 Port M_LRSEL  output  1: microphone channel select; tied 0.
REQ-009 Port data_o  output  WORD_W: last completed word; earliest sample in MSB.
REQ-010 Port ones_o  output  $clog2(WORD_W+1): count of 1-samples in data_o (PCM density).
REQ-011 Port one_done  output  1: one-cycle word-complete strobe; advances the controller's memory address.

Function
REQ-012 Exactly two states, IDLE and RUN; IDLE->RUN on any edge with D_enable=1; RUN->IDLE on any edge with D_enable=0.
REQ-013 IDLE: div_cnt=0, M_CLK=0, bit_cnt=0, shift register=0, ones accumulator=0, one_done=0; data_o and ones_o hold their last values.
REQ-014 Cycle numbering: edge 0 = edge that moves IDLE->RUN; after edge k in RUN, div_cnt = k mod CLK_DIV.
REQ-015 RUN: div_cnt increments every edge; when div_cnt==CLK_DIV-1 it wraps to 0 and M_CLK toggles on that edge.
REQ-016 First M_CLK rise on edge CLK_DIV; subsequent rises every 2*CLK_DIV edges.
REQ-017 Sampling occurs only on an edge where M_CLK toggles 0->1: shift <= {shift[WORD_W-2:0], pdm_data_i}, ones accumulator += pdm_data_i, bit_cnt += 1.
REQ-018 On the sampling edge that takes the WORD_W-th sample: data_o <= {shift[WORD_W-2:0], pdm_data_i}, ones_o <= accumulator + pdm_data_i, one_done <= 1, bit_cnt/accumulator <= 0.
REQ-019 one_done is high for exactly one cycle per word; all other cycles 0.
REQ-020 Steady-state one_done period = 2*CLK_DIV*WORD_W edges (1600 at defaults).
REQ-021 bit_cnt never exceeds WORD_W-1 between words; accumulator width $clog2(WORD_W+1), no overflow.
REQ-022 D_enable=0 on the edge that would take the WORD_W-th sample: IDLE wins; word discarded, no one_done, data_o unchanged.
REQ-023 Partial word on RUN->IDLE is discarded; re-entry starts a fresh word from bit 0 with timing per REQ-014/016.
REQ-024 M_LRSEL = 0 at all times, including during reset.

Reset
REQ-025 Reset_n=0 forces, immediately and without a clock edge: state=IDLE, M_CLK=0, data_o=0, ones_o=0, one_done=0, all counters and shift register 0.
REQ-026 Reset deassertion is synchronised upstream; first state evaluation on the next clock_i rising edge.
REQ-027 Reset mid-word discards the partial word; no one_done is produced for it.

Verification
REQ-028 Reset: Reset_n=0 with clock stopped -> M_CLK=0, one_done=0, data_o=0, ones_o=0 immediately.
REQ-029 D_enable=1, pdm_data_i=1 constant -> M_CLK first rises at edge 50; one_done high for one cycle after edge 1550; data_o=16'hFFFF, ones_o=16.
REQ-030 pdm_data_i alternating 1,0,... starting at first sample -> data_o=16'hAAAA, ones_o=8; next one_done 1600 edges later.
REQ-031 D_enable dropped after 8 samples, re-raised 10 cycles later -> no one_done, M_CLK=0 while idle; next word needs 16 fresh samples, data_o unchanged until then.
REQ-032 Reset_n pulsed low mid-word (sample 5) -> outputs 0 asynchronously; after release with D_enable=1, first one_done again at edge 1550 from re-entry.
REQ-033 D_enable=0 on the 16th-sample edge -> no one_done, data_o retains previous word.
